// File: rtl/mem_access_master.sv
// Load/store initiator for a single-cycle 64-bit memory port: one request at a time,
// lane alignment of store data and masks, and two-beat handling of 8-byte boundary crossings.
module mem_access_master #(
    parameter bit ALLOW_SPLIT = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wData,
    output logic [7:0]  mem_wMask,
    input  logic [63:0] mem_rData
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state, state_nxt;
    logic        r_wen;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] lo_buf;
    logic [63:0] hi_buf;
    logic [63:0] rdata_q;
    logic        err_q;

    logic [2:0]  off;
    logic [3:0]  nbytes;
    logic [15:0] m16;
    logic        go_acc1;
    logic [2:0]  in_align_mask;
    logic        in_misaligned;
    logic [63:0] ext_lo;
    logic [63:0] ext_hi;
    logic [63:0] v;
    logic [63:0] load_val;

    assign off           = r_addr[2:0];
    assign nbytes        = 4'd1 << r_size;
    assign m16           = ((16'd1 << nbytes) - 16'd1) << off;
    assign go_acc1       = ALLOW_SPLIT && (({1'b0, off} + nbytes) > 4'd8);
    // For a double the shift wraps to 0, so the alignment mask becomes 3'b111.
    assign in_align_mask = (3'd1 << req_size) - 3'd1;
    assign in_misaligned = (req_addr[2:0] & in_align_mask) != 3'd0;

    // The beat in flight supplies its half directly, so rdata can register on entry to RESP.
    assign ext_lo = (state == ACC0) ? mem_rData : lo_buf;
    assign ext_hi = (state == ACC1) ? mem_rData : hi_buf;
    assign v      = 64'({ext_hi, ext_lo} >> {off, 3'b000});

    always_comb begin
        load_val = v;
        case (r_size)
            2'd0:    load_val = r_signed ? {{56{v[7]}},  v[7:0]}  : {56'd0, v[7:0]};
            2'd1:    load_val = r_signed ? {{48{v[15]}}, v[15:0]} : {48'd0, v[15:0]};
            2'd2:    load_val = r_signed ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]};
            default: load_val = v;
        endcase
    end

    // NOTE: every output of this block gets a default before the case, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = 64'd0;
        mem_wData  = 64'd0;
        mem_wMask  = 8'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = (!ALLOW_SPLIT && in_misaligned) ? RESP : ACC0;
            end
            ACC0: begin
                mem_en    = 1'b1;
                mem_addr  = {r_addr[63:3], 3'b000};
                mem_wData = r_wdata << {off, 3'b000};
                mem_wMask = r_wen ? m16[7:0] : 8'd0;
                state_nxt = go_acc1 ? ACC1 : RESP;
            end
            ACC1: begin
                mem_en    = 1'b1;
                mem_addr  = {r_addr[63:3], 3'b000} + 64'd8;
                mem_wData = r_wdata >> {(4'd8 - {1'b0, off}), 3'b000};
                mem_wMask = r_wen ? m16[15:8] : 8'd0;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wen    <= 1'b0;
            r_size   <= 2'd0;
            r_signed <= 1'b0;
            r_addr   <= 64'd0;
            r_wdata  <= 64'd0;
            lo_buf   <= 64'd0;
            hi_buf   <= 64'd0;
            rdata_q  <= 64'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_wen    <= req_wen;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        rdata_q  <= 64'd0;
                        err_q    <= !ALLOW_SPLIT && in_misaligned;
                    end
                end
                ACC0: begin
                    lo_buf <= mem_rData;
                    if (!go_acc1)
                        rdata_q <= r_wen ? 64'd0 : load_val;
                end
                ACC1: begin
                    hi_buf  <= mem_rData;
                    rdata_q <= r_wen ? 64'd0 : load_val;
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master: a split-capable instance for the main sequence
// and a no-split instance for misaligned rejection.
module tb_mem_access_master;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    // split-capable instance
    logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [63:0] resp_rdata;
    logic        mem_en;
    logic [63:0] mem_addr, mem_wData, mem_rData;
    logic [7:0]  mem_wMask;
    logic [63:0] rd_data0 = 64'd0, rd_data1 = 64'd0, rd_addr1 = 64'd1;

    // no-split instance
    logic        n_req_valid = 1'b0, n_req_ready, n_req_wen = 1'b0, n_req_signed = 1'b0;
    logic [1:0]  n_req_size = 2'd0;
    logic [63:0] n_req_addr = 64'd0, n_req_wdata = 64'd0;
    logic        n_resp_valid, n_resp_ready = 1'b0, n_resp_err;
    logic [63:0] n_resp_rdata;
    logic        n_mem_en;
    logic [63:0] n_mem_addr, n_mem_wData;
    logic [63:0] n_mem_rData = 64'd0;
    logic [7:0]  n_mem_wMask;
    logic        n_en_seen = 1'b0;

    // beat log of the split-capable instance
    logic [63:0] b_addr[64];
    logic [63:0] b_wdata[64];
    logic [7:0]  b_mask[64];
    int          b_cyc[64];
    int          nb = 0;

    assign mem_rData = (mem_addr == rd_addr1) ? rd_data1 : rd_data0;

    mem_access_master #(.ALLOW_SPLIT(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en),
        .mem_addr(mem_addr), .mem_wData(mem_wData), .mem_wMask(mem_wMask),
        .mem_rData(mem_rData)
    );

    mem_access_master #(.ALLOW_SPLIT(1'b0)) dut_ns (
        .clock(clock), .reset_n(reset_n),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_wen(n_req_wen),
        .req_size(n_req_size), .req_signed(n_req_signed), .req_addr(n_req_addr),
        .req_wdata(n_req_wdata), .resp_valid(n_resp_valid), .resp_ready(n_resp_ready),
        .resp_rdata(n_resp_rdata), .resp_err(n_resp_err), .mem_en(n_mem_en),
        .mem_addr(n_mem_addr), .mem_wData(n_mem_wData), .mem_wMask(n_mem_wMask),
        .mem_rData(n_mem_rData)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge n_mem_en) n_en_seen = 1'b1;

    always @(negedge clock) begin
        if (mem_en === 1'b1 && nb < 64) begin
            b_addr[nb]  = mem_addr;
            b_wdata[nb] = mem_wData;
            b_mask[nb]  = mem_wMask;
            b_cyc[nb]   = cyc;
            nb = nb + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge; t_acc is the cycle whose rising edge accepts it.
    task automatic issue(input logic wen, input logic [1:0] size, input logic sgn,
                         input logic [63:0] addr, input logic [63:0] wdata, output int t_acc);
        @(negedge clock);
        req_wen = wen; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clock);
        t_acc = cyc;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, output int t_resp);
        for (int i = 0; i < 20 && resp_valid !== 1'b1; i++) @(negedge clock);
        check({tag, "_resp_seen"}, 64'(resp_valid), 64'd1);
        t_resp = cyc;
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    initial begin
        int ta, tr, nb0;

        // reset state
        repeat (2) @(negedge clock);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wData, 64'd0);
        check("rst_mem_mask", 64'(mem_wMask), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        reset_n = 1'b1;

        // 1: aligned SD
        nb0 = nb;
        issue(1'b1, 2'd3, 1'b0, 64'h8000_0000, 64'h1122_3344_5566_7788, ta);
        wait_resp("t1", tr);
        check("t1_nbeats", 64'(nb - nb0), 64'd1);
        check("t1_beat_cyc", 64'(b_cyc[nb0] - ta), 64'd1);
        check("t1_addr", b_addr[nb0], 64'h8000_0000);
        check("t1_mask", 64'(b_mask[nb0]), 64'hFF);
        check("t1_wdata", b_wdata[nb0], 64'h1122_3344_5566_7788);
        check("t1_resp_cyc", 64'(tr - ta), 64'd2);
        check("t1_rdata", resp_rdata, 64'd0);
        check("t1_err", 64'(resp_err), 64'd0);
        handshake();

        // 2: LB signed and unsigned
        rd_data0 = 64'h0000_0000_8000_0000;
        nb0 = nb;
        issue(1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'd0, ta);
        wait_resp("t2s", tr);
        check("t2s_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        check("t2s_mask", 64'(b_mask[nb0]), 64'h00);
        check("t2s_resp_cyc", 64'(tr - ta), 64'd2);
        handshake();
        nb0 = nb;
        issue(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'd0, ta);
        wait_resp("t2u", tr);
        check("t2u_rdata", resp_rdata, 64'h80);
        check("t2u_mask", 64'(b_mask[nb0]), 64'h00);
        handshake();

        // 3: split SW
        nb0 = nb;
        issue(1'b1, 2'd2, 1'b0, 64'h8000_0006, 64'hAABB_CCDD, ta);
        wait_resp("t3", tr);
        check("t3_nbeats", 64'(nb - nb0), 64'd2);
        check("t3_b0_cyc", 64'(b_cyc[nb0] - ta), 64'd1);
        check("t3_b0_addr", b_addr[nb0], 64'h8000_0000);
        check("t3_b0_mask", 64'(b_mask[nb0]), 64'hC0);
        check("t3_b0_wdata", b_wdata[nb0], 64'hCCDD_0000_0000_0000);
        check("t3_b1_cyc", 64'(b_cyc[nb0+1] - ta), 64'd2);
        check("t3_b1_addr", b_addr[nb0+1], 64'h8000_0008);
        check("t3_b1_mask", 64'(b_mask[nb0+1]), 64'h03);
        check("t3_b1_wdata", b_wdata[nb0+1], 64'hAABB);
        check("t3_resp_cyc", 64'(tr - ta), 64'd3);
        check("t3_rdata", resp_rdata, 64'd0);
        handshake();

        // 4: split LD
        rd_data0 = 64'h4433_2211_CAFE_BABE;
        rd_addr1 = 64'h8000_0008;
        rd_data1 = 64'h1234_5678_8877_6655;
        nb0 = nb;
        issue(1'b0, 2'd3, 1'b0, 64'h8000_0004, 64'd0, ta);
        wait_resp("t4", tr);
        check("t4_nbeats", 64'(nb - nb0), 64'd2);
        check("t4_b1_addr", b_addr[nb0+1], 64'h8000_0008);
        check("t4_masks", 64'({b_mask[nb0], b_mask[nb0+1]}), 64'd0);
        check("t4_resp_cyc", 64'(tr - ta), 64'd3);
        check("t4_rdata", resp_rdata, 64'h8877_6655_4433_2211);
        handshake();
        rd_addr1 = 64'd1;

        // 5: response back-pressure with the next request already pending
        rd_data0 = 64'h0000_0000_8001_0000;
        issue(1'b0, 2'd1, 1'b1, 64'h8000_0002, 64'd0, ta);
        wait_resp("t5", tr);
        req_wen = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 64'h8000_0020; req_wdata = 64'h5A; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", 64'(resp_valid), 64'd1);
            check("t5_hold_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_8001);
            check("t5_hold_err", 64'(resp_err), 64'd0);
            check("t5_hold_req_ready", 64'(req_ready), 64'd0);
            check("t5_hold_mem_en", 64'(mem_en), 64'd0);
            @(negedge clock);
        end
        nb0 = nb;
        handshake();
        check("t5_next_req_ready", 64'(req_ready), 64'd1);
        check("t5_resp_dropped", 64'(resp_valid), 64'd0);
        ta = cyc;
        @(negedge clock);
        req_valid = 1'b0;
        wait_resp("t5b", tr);
        check("t5b_resp_cyc", 64'(tr - ta), 64'd2);
        check("t5b_addr", b_addr[nb0], 64'h8000_0020);
        check("t5b_mask", 64'(b_mask[nb0]), 64'h01);
        check("t5b_wdata", b_wdata[nb0], 64'h5A);
        handshake();

        // 6: reset during the first beat of a split store
        nb0 = nb;
        issue(1'b1, 2'd3, 1'b0, 64'h8000_0005, 64'h0102_0304_0506_0708, ta);
        check("t6_b0_en", 64'(mem_en), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_mem_en", 64'(mem_en), 64'd0);
        check("t6_rst_mem_mask", 64'(mem_wMask), 64'd0);
        check("t6_rst_mem_addr", mem_addr, 64'd0);
        check("t6_rst_mem_wdata", mem_wData, 64'd0);
        check("t6_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("t6_rst_req_ready", 64'(req_ready), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("t6_nbeats", 64'(nb - nb0), 64'd1);
        check("t6_b0_mask", 64'(b_mask[nb0]), 64'hE0);
        check("t6_b0_wdata", b_wdata[nb0], 64'h0607_0800_0000_0000);
        check("t6_no_resp", 64'(resp_valid), 64'd0);

        // 7: no-split instance rejects a misaligned LH, then serves an aligned one
        @(negedge clock);
        n_req_wen = 1'b0; n_req_size = 2'd1; n_req_signed = 1'b0;
        n_req_addr = 64'h1; n_req_valid = 1'b1;
        check("t7_req_ready", 64'(n_req_ready), 64'd1);
        @(negedge clock);
        n_req_valid = 1'b0;
        check("t7_err_valid_t1", 64'(n_resp_valid), 64'd1);
        check("t7_err", 64'(n_resp_err), 64'd1);
        check("t7_err_rdata", n_resp_rdata, 64'd0);
        n_resp_ready = 1'b1;
        @(negedge clock);
        n_resp_ready = 1'b0;
        check("t7_no_mem_en", 64'(n_en_seen), 64'd0);
        n_mem_rData = 64'h0000_0000_1234_0000;
        n_req_addr = 64'h2; n_req_valid = 1'b1;
        @(negedge clock);
        n_req_valid = 1'b0;
        check("t7b_mem_en", 64'(n_mem_en), 64'd1);
        check("t7b_mem_addr", n_mem_addr, 64'd0);
        check("t7b_not_yet", 64'(n_resp_valid), 64'd0);
        @(negedge clock);
        check("t7b_valid_t2", 64'(n_resp_valid), 64'd1);
        check("t7b_rdata", n_resp_rdata, 64'h1234);
        check("t7b_err", 64'(n_resp_err), 64'd0);
        n_resp_ready = 1'b1;
        @(negedge clock);
        n_resp_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
